dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between NUM_REQ L1 caches (one per core): miss refills (reads) and store write-throughs.
//  Round-robin grant, one transaction in flight, fixed-latency memory. Sits between the per-core cache_subsystem_L1 instances and dmem.
// PARAMETERS
//  NUM_REQ  2   number of requesting L1 caches (>=2)
//  ADDR_W   10  dmem address width
//  DATA_W   32  data width; byte enables are DATA_W/8 bits
//  MEM_LAT  2   dmem read latency in cycles (>=1)
// PORTS
//  clk         in   1                    clock; all state updates on rising edge
//  reset       in   1                    asynchronous, active-low reset (0 = reset)
//  req_valid   in   NUM_REQ              per-requester request; held until req_ready seen
//  req_we      in   NUM_REQ              1 = write, 0 = read
//  req_addr    in   NUM_REQ*ADDR_W       packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata   in   NUM_REQ*DATA_W       packed write data
//  req_be      in   NUM_REQ*DATA_W/8     packed byte enables (writes only)
//  req_ready   out  NUM_REQ              one-hot accept pulse; transfer = req_valid[i] & req_ready[i]
//  resp_valid  out  NUM_REQ              one-hot, one-cycle completion pulse to the granted requester
//  resp_rdata  out  DATA_W               read data, valid with resp_valid; 0 for write responses
//  busy        out  1                    1 whenever the FSM is not in IDLE
//  mem_en      out  1                    dmem access strobe, exactly one cycle per transaction
//  mem_we      out  1                    dmem write enable (qualified by mem_en)
//  mem_addr    out  ADDR_W               dmem address
//  mem_wdata   out  DATA_W               dmem write data
//  mem_be      out  DATA_W/8             dmem byte enables
//  mem_rdata   in   DATA_W               valid exactly MEM_LAT cycles after the mem_en read cycle
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, rr_ptr=0, latched txn fields=0; all outputs 0; in-flight txn dropped, late mem_rdata ignored.
//  All outputs registered or decoded from registered state only; no comb path from req_* to mem_*.
//  FSM IDLE -> ISSUE -> (read: WAIT) -> RESP -> IDLE.
//   IDLE : if any req_valid: pick g = first index with req_valid set, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//          req_ready[g]=1 this cycle; latch g, we, addr, wdata, be; -> ISSUE. No request: stay, all outputs 0.
//   ISSUE: mem_en=1 with latched we/addr/wdata/be (mem_be forced 0 on reads). Write -> RESP. Read -> WAIT, cnt=MEM_LAT-1.
//   WAIT : cnt decrements each cycle; when cnt==0 capture mem_rdata into rdata reg, -> RESP.
//          (MEM_LAT=1: WAIT lasts one cycle, captures at ISSUE+1.)
//   RESP : resp_valid[g]=1, resp_rdata=rdata reg (0 if write); rr_ptr <= (g+1) mod NUM_REQ; -> IDLE.
//  Latency from accept cycle t: write resp at t+2; read resp at t+MEM_LAT+2. Next accept earliest cycle after RESP.
//  Requests are accepted only in IDLE; a req_valid held through ISSUE/WAIT/RESP waits; no request is ever lost or duplicated.
//  Fairness: a continuously-requesting requester is granted within NUM_REQ transactions.
//  req_valid deasserted before grant: simply not considered; no error.
//  Only the latched copy drives mem_*; requester may change req_* after the accept cycle.
//  Assertions: req_ready and resp_valid each one-hot or zero; mem_en never high in two consecutive cycles.
// TESTING
//  1 Reset: reset=0 mid-WAIT -> all outputs 0 same cycle, state IDLE, rr_ptr=0; mem_rdata 0xDEAD arriving later never returned.
//  2 Single read: req0 read addr 0x044, dmem word 0x11223344, MEM_LAT=2 -> req_ready[0] at t, mem_en t+1, resp_valid[0] t+4, rdata 0x11223344.
//  3 Single write: req1 write addr 0x3FC data 0xCAFEBABE be 4'b0011 -> mem_en/mem_we at t+1 with be 0011, resp_valid[1] t+2, resp_rdata 0.
//  4 Simultaneous: req0 and req1 both valid from reset -> grant order 0,1,0,1 over four txns; no starvation.
//  5 Back-to-back: req1 held during req0's WAIT -> req1 accepted the cycle after req0's RESP; mem_en never adjacent.
//  6 MEM_LAT=1 and MEM_LAT=4 builds: read resp at t+3 and t+6 respectively with correct data.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared data-memory port.
// The arbiter takes the slave view; caches plus dmem (or a bench) take the master view.
interface dmem_port_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*BE_W-1:0]   req_be;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_rdata;
    logic                      busy;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [BE_W-1:0]           mem_be;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, mem_rdata,
        output req_ready, resp_valid, resp_rdata, busy,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, busy,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency dmem port between NUM_REQ L1 caches.
// One transaction in flight: IDLE -> ISSUE -> (WAIT for reads) -> RESP -> IDLE.
module dmem_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    dmem_port_arbiter_if.slave bus
);
    localparam int BE_W   = DATA_W / 8;
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int SCAN_W = IDX_W + 1;
    localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [SCAN_W-1:0] NUM_REQ_EXT = SCAN_W'(NUM_REQ);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]  CNT_INIT    = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    grant_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [SCAN_W-1:0]   scan;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic                issue;
    logic                resp;

    // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr_q} + SCAN_W'(k);
            if (scan >= NUM_REQ_EXT) begin
                scan = scan - NUM_REQ_EXT;
            end
            if (!pick_found && bus.req_valid[scan[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        case (state_q)
            IDLE: begin
                // The accept pulse is gated by reset so every output reads 0 while held in reset.
                if (pick_found && reset) begin
                    bus.req_ready[pick_idx] = 1'b1;
                    state_d                 = ISSUE;
                end
            end
            ISSUE:   state_d = we_q ? RESP : WAIT;
            WAIT:    state_d = (cnt_q == '0) ? RESP : WAIT;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        we_q    <= bus.req_we[pick_idx];
                        addr_q  <= bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
                        wdata_q <= bus.req_wdata[pick_idx*DATA_W +: DATA_W];
                        be_q    <= bus.req_be[pick_idx*BE_W +: BE_W];
                        rdata_q <= '0;
                    end
                end
                ISSUE: cnt_q <= CNT_INIT;
                WAIT: begin
                    if (cnt_q == '0) begin
                        rdata_q <= bus.mem_rdata;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: rr_ptr_q <= (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        grant_onehot          = '0;
        grant_onehot[grant_q] = 1'b1;
    end

    // Memory and response outputs decode only from registered state and the latched copy.
    assign issue          = (state_q == ISSUE);
    assign resp           = (state_q == RESP);
    assign bus.busy       = (state_q != IDLE);
    assign bus.mem_en     = issue;
    assign bus.mem_we     = issue & we_q;
    assign bus.mem_addr   = issue ? addr_q : '0;
    assign bus.mem_wdata  = issue ? wdata_q : '0;
    assign bus.mem_be     = (issue && we_q) ? be_q : '0;
    assign bus.resp_valid = resp ? grant_onehot : '0;
    assign bus.resp_rdata = resp ? rdata_q : '0;

    ready_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(bus.req_ready));
    resp_onehot:  assert property (@(posedge clk) disable iff (!reset) $onehot0(bus.resp_valid));
    mem_en_gap:   assert property (@(posedge clk) disable iff (!reset) bus.mem_en |=> !bus.mem_en);
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: MEM_LAT=2 main instance plus MEM_LAT=1 and MEM_LAT=4 builds.
// Memory is a fixed image returned through a MEM_LAT-deep pipe, idle filler 0xFFFFFFFF.
module tb_dmem_port_arbiter;
    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int          assert_count = 0;
    int          fail_count   = 0;
    int          cyc          = 0;
    int          adj_count    = 0;
    int          waited;
    int          acc_cyc;
    logic        prev_mem_en  = 1'b0;
    logic [1:0]  exp_grant;
    logic [31:0] exp_data;
    logic [31:0] pipe1;
    logic [31:0] pipe2 [2];
    logic [31:0] pipe4 [4];

    dmem_port_arbiter_if #(.NUM_REQ(2), .ADDR_W(10), .DATA_W(32)) b1 ();
    dmem_port_arbiter_if #(.NUM_REQ(2), .ADDR_W(10), .DATA_W(32)) b2 ();
    dmem_port_arbiter_if #(.NUM_REQ(2), .ADDR_W(10), .DATA_W(32)) b4 ();

    dmem_port_arbiter #(.NUM_REQ(2), .ADDR_W(10), .DATA_W(32), .MEM_LAT(1)) u_dut_lat1 (
        .clk(clk), .reset(reset), .bus(b1.slave));
    dmem_port_arbiter #(.NUM_REQ(2), .ADDR_W(10), .DATA_W(32), .MEM_LAT(2)) u_dut_lat2 (
        .clk(clk), .reset(reset), .bus(b2.slave));
    dmem_port_arbiter #(.NUM_REQ(2), .ADDR_W(10), .DATA_W(32), .MEM_LAT(4)) u_dut_lat4 (
        .clk(clk), .reset(reset), .bus(b4.slave));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_image(input logic [9:0] a);
        case (a)
            10'h044: return 32'h1122_3344;
            10'h100: return 32'h0000_DEAD;
            default: return {16'hB000, 6'h00, a};
        endcase
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        pipe1    <= (b1.mem_en && !b1.mem_we) ? mem_image(b1.mem_addr) : 32'hFFFF_FFFF;
        pipe2[0] <= (b2.mem_en && !b2.mem_we) ? mem_image(b2.mem_addr) : 32'hFFFF_FFFF;
        pipe2[1] <= pipe2[0];
        pipe4[0] <= (b4.mem_en && !b4.mem_we) ? mem_image(b4.mem_addr) : 32'hFFFF_FFFF;
        pipe4[1] <= pipe4[0];
        pipe4[2] <= pipe4[1];
        pipe4[3] <= pipe4[2];
        if (b2.mem_en && prev_mem_en) adj_count <= adj_count + 1;
        prev_mem_en <= b2.mem_en;
    end

    assign b1.mem_rdata = pipe1;
    assign b2.mem_rdata = pipe2[1];
    assign b4.mem_rdata = pipe4[3];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int i, input logic valid, input logic we, input logic [9:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        b2.req_valid[i]          = valid;
        b2.req_we[i]             = we;
        b2.req_addr[i*10 +: 10]  = addr;
        b2.req_wdata[i*32 +: 32] = wdata;
        b2.req_be[i*4 +: 4]      = be;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        b1.req_valid = '0; b1.req_we = '0; b1.req_addr = '0; b1.req_wdata = '0; b1.req_be = '0;
        b2.req_valid = '0; b2.req_we = '0; b2.req_addr = '0; b2.req_wdata = '0; b2.req_be = '0;
        b4.req_valid = '0; b4.req_we = '0; b4.req_addr = '0; b4.req_wdata = '0; b4.req_be = '0;

        // Both requesters valid from reset; nothing may be accepted while reset is held.
        applyStimulus(0, 1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_req_ready", b2.req_ready, 32'h0);
        checkOutput("rst_busy", b2.busy, 32'h0);
        checkOutput("rst_mem_en", b2.mem_en, 32'h0);
        checkOutput("rst_resp_valid", b2.resp_valid, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_data  = (k % 2 == 0) ? 32'hB000_0010 : 32'hB000_0020;
            waited = 0;
            while (b2.req_ready == 2'b00 && waited < 20) begin
                @(negedge clk); #1; waited++;
            end
            acc_cyc = cyc;
            checkOutput("t4_grant", b2.req_ready, exp_grant);
            @(negedge clk);
            if (k == 3) begin
                applyStimulus(0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
                applyStimulus(1, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
            end
            #1;
            waited = 0;
            while (b2.resp_valid == 2'b00 && waited < 20) begin
                @(negedge clk); #1; waited++;
            end
            checkOutput("t4_resp_valid", b2.resp_valid, exp_grant);
            checkOutput("t4_resp_rdata", b2.resp_rdata, exp_data);
            checkOutput("t4_latency", cyc - acc_cyc, 32'd4);
        end

        // Single read from requester 0.
        @(negedge clk); applyStimulus(0, 1'b1, 1'b0, 10'h044, 32'h0, 4'hF); #1;
        checkOutput("t2_ready", b2.req_ready, 32'h1);
        @(negedge clk); applyStimulus(0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0); #1;
        checkOutput("t2_mem_en", b2.mem_en, 32'h1);
        checkOutput("t2_mem_we", b2.mem_we, 32'h0);
        checkOutput("t2_mem_addr", b2.mem_addr, 32'h044);
        checkOutput("t2_mem_be", b2.mem_be, 32'h0);
        @(negedge clk); #1;
        checkOutput("t2_wait_mem_en", b2.mem_en, 32'h0);
        checkOutput("t2_wait_busy", b2.busy, 32'h1);
        @(negedge clk); #1;
        checkOutput("t2_early_resp", b2.resp_valid, 32'h0);
        @(negedge clk); #1;
        checkOutput("t2_resp_valid", b2.resp_valid, 32'h1);
        checkOutput("t2_resp_rdata", b2.resp_rdata, 32'h1122_3344);
        @(negedge clk); #1;
        checkOutput("t2_idle_busy", b2.busy, 32'h0);
        checkOutput("t2_idle_resp", b2.resp_valid, 32'h0);

        // Reset lands mid-WAIT; the late 0xDEAD word must never be returned.
        @(negedge clk); applyStimulus(0, 1'b1, 1'b0, 10'h100, 32'h0, 4'h0); #1;
        checkOutput("t1_ready", b2.req_ready, 32'h1);
        @(negedge clk); applyStimulus(0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0); #1;
        checkOutput("t1_mem_en", b2.mem_en, 32'h1);
        @(negedge clk); reset = 1'b0; #1;
        checkOutput("t1_rst_busy", b2.busy, 32'h0);
        checkOutput("t1_rst_mem_en", b2.mem_en, 32'h0);
        checkOutput("t1_rst_mem_addr", b2.mem_addr, 32'h0);
        checkOutput("t1_rst_resp_valid", b2.resp_valid, 32'h0);
        checkOutput("t1_rst_resp_rdata", b2.resp_rdata, 32'h0);
        @(negedge clk); reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checkOutput("t1_late_resp_valid", b2.resp_valid, 32'h0);
            checkOutput("t1_late_resp_rdata", b2.resp_rdata, 32'h0);
            checkOutput("t1_late_busy", b2.busy, 32'h0);
            @(negedge clk);
        end
        applyStimulus(0, 1'b1, 1'b0, 10'h010, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b0, 10'h020, 32'h0, 4'h0);
        #1;
        checkOutput("t1_rr_ptr_cleared", b2.req_ready, 32'h1);
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
        #1;
        waited = 0;
        while (b2.busy && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        checkOutput("t1_drain_busy", b2.busy, 32'h0);

        // Single write from requester 1; its inputs change right after the accept.
        @(negedge clk); applyStimulus(1, 1'b1, 1'b1, 10'h3FC, 32'hCAFE_BABE, 4'b0011); #1;
        checkOutput("t3_ready", b2.req_ready, 32'h2);
        @(negedge clk); applyStimulus(1, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0); #1;
        checkOutput("t3_mem_en", b2.mem_en, 32'h1);
        checkOutput("t3_mem_we", b2.mem_we, 32'h1);
        checkOutput("t3_mem_addr", b2.mem_addr, 32'h3FC);
        checkOutput("t3_mem_wdata", b2.mem_wdata, 32'hCAFE_BABE);
        checkOutput("t3_mem_be", b2.mem_be, 32'h3);
        @(negedge clk); #1;
        checkOutput("t3_resp_valid", b2.resp_valid, 32'h2);
        checkOutput("t3_resp_rdata", b2.resp_rdata, 32'h0);
        @(negedge clk); #1;
        checkOutput("t3_idle_busy", b2.busy, 32'h0);

        // Requester 1 raises its write while requester 0's read is in WAIT.
        @(negedge clk); applyStimulus(0, 1'b1, 1'b0, 10'h044, 32'h0, 4'h0); #1;
        checkOutput("t5_ready0", b2.req_ready, 32'h1);
        @(negedge clk); applyStimulus(0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0); #1;
        checkOutput("t5_mem_en0", b2.mem_en, 32'h1);
        @(negedge clk); applyStimulus(1, 1'b1, 1'b1, 10'h155, 32'h1234_5678, 4'hF); #1;
        checkOutput("t5_hold_wait", b2.req_ready, 32'h0);
        @(negedge clk); #1;
        checkOutput("t5_hold_wait2", b2.req_ready, 32'h0);
        @(negedge clk); #1;
        checkOutput("t5_resp0_valid", b2.resp_valid, 32'h1);
        checkOutput("t5_resp0_rdata", b2.resp_rdata, 32'h1122_3344);
        checkOutput("t5_hold_resp", b2.req_ready, 32'h0);
        @(negedge clk); #1;
        checkOutput("t5_ready1", b2.req_ready, 32'h2);
        checkOutput("t5_idle_mem_en", b2.mem_en, 32'h0);
        @(negedge clk); applyStimulus(1, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0); #1;
        checkOutput("t5_mem_en1", b2.mem_en, 32'h1);
        checkOutput("t5_mem_we1", b2.mem_we, 32'h1);
        checkOutput("t5_mem_addr1", b2.mem_addr, 32'h155);
        checkOutput("t5_mem_wdata1", b2.mem_wdata, 32'h1234_5678);
        @(negedge clk); #1;
        checkOutput("t5_resp1_valid", b2.resp_valid, 32'h2);
        @(negedge clk); #1;
        checkOutput("t5_idle_busy", b2.busy, 32'h0);

        // MEM_LAT=1 and MEM_LAT=4 builds: read responses at t+3 and t+6.
        @(negedge clk);
        b1.req_valid = 2'b01; b1.req_we = 2'b00; b1.req_addr = {10'h000, 10'h0AB};
        b4.req_valid = 2'b01; b4.req_we = 2'b00; b4.req_addr = {10'h000, 10'h1CD};
        #1;
        checkOutput("t6_lat1_ready", b1.req_ready, 32'h1);
        checkOutput("t6_lat4_ready", b4.req_ready, 32'h1);
        @(negedge clk);
        b1.req_valid = 2'b00;
        b4.req_valid = 2'b00;
        #1;
        checkOutput("t6_lat1_mem_en", b1.mem_en, 32'h1);
        checkOutput("t6_lat4_mem_en", b4.mem_en, 32'h1);
        @(negedge clk); #1;
        checkOutput("t6_lat1_early", b1.resp_valid, 32'h0);
        @(negedge clk); #1;
        checkOutput("t6_lat1_resp_valid", b1.resp_valid, 32'h1);
        checkOutput("t6_lat1_resp_rdata", b1.resp_rdata, 32'hB000_00AB);
        checkOutput("t6_lat4_not_yet", b4.resp_valid, 32'h0);
        @(negedge clk); @(negedge clk); #1;
        checkOutput("t6_lat4_early", b4.resp_valid, 32'h0);
        @(negedge clk); #1;
        checkOutput("t6_lat4_resp_valid", b4.resp_valid, 32'h1);
        checkOutput("t6_lat4_resp_rdata", b4.resp_rdata, 32'hB000_01CD);

        checkOutput("mem_en_adjacent", adj_count, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
